pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline hazard status inputs and stage control outputs
interface pipe_hazard_ctrl_if;
   logic        d_valid;
   logic [4:0]  d_rs;
   logic [4:0]  d_rt;
   logic [4:0]  e_dst;
   logic        e_reg_write;
   logic        e_mem_to_reg;
   logic [4:0]  m_dst;
   logic        m_reg_write;
   logic [4:0]  w_dst;
   logic        w_reg_write;
   logic        branch_judge;
   logic        dreq_valid;
   logic        dresp_ready;
   logic        fetch_enable;
   logic        decode_enable;
   logic        execute_enable;
   logic        memory_enable;
   logic        writeback_enable;
   logic        flush_decode;
   logic        flush_execute;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [1:0]  state;
   logic [15:0] stall_count;

   modport master (
      output d_valid, d_rs, d_rt, e_dst, e_reg_write, e_mem_to_reg,
             m_dst, m_reg_write, w_dst, w_reg_write,
             branch_judge, dreq_valid, dresp_ready,
      input  fetch_enable, decode_enable, execute_enable, memory_enable, writeback_enable,
             flush_decode, flush_execute, fwd_a, fwd_b, state, stall_count
   );

   modport slave (
      input  d_valid, d_rs, d_rt, e_dst, e_reg_write, e_mem_to_reg,
             m_dst, m_reg_write, w_dst, w_reg_write,
             branch_judge, dreq_valid, dresp_ready,
      output fetch_enable, decode_enable, execute_enable, memory_enable, writeback_enable,
             flush_decode, flush_execute, fwd_a, fwd_b, state, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding control for a five-stage pipeline
module pipe_hazard_ctrl (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  hz
);
   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      BR_FLUSH   = 2'b10,
      MEM_WAIT   = 2'b11
   } state_t;

   state_t      cur_state;
   state_t      nxt_state;
   logic [4:0]  en;
   logic        fl_d;
   logic        fl_e;
   logic [15:0] stall_cnt;
   logic        load_use;
   logic        mem_block;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] mdst, input logic mwr,
                                          input logic [4:0] wdst, input logic wwr);
      if (mwr && mdst != 5'd0 && mdst == src)
         return 2'b01;
      else if (wwr && wdst != 5'd0 && wdst == src)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign load_use  = hz.d_valid & hz.e_mem_to_reg & hz.e_reg_write & (hz.e_dst != 5'd0) &
                      ((hz.e_dst == hz.d_rs) | (hz.e_dst == hz.d_rt));
   assign mem_block = hz.dreq_valid & ~hz.dresp_ready;

   // Stage controls are Mealy: a stall must freeze the pipe in the same cycle the hazard is seen.
   always_comb begin
      en        = 5'b11111;
      fl_d      = 1'b0;
      fl_e      = 1'b0;
      nxt_state = RUN;
      if (!reset) begin
         en   = 5'b00000;
         fl_d = 1'b1;
         fl_e = 1'b1;
      end else begin
         case (cur_state)
            RUN: begin
               if (mem_block) begin
                  en        = 5'b00000;
                  nxt_state = MEM_WAIT;
               end else if (hz.branch_judge) begin
                  fl_d      = 1'b1;
                  fl_e      = 1'b1;
                  nxt_state = BR_FLUSH;
               end else if (load_use) begin
                  en        = 5'b00011;
                  nxt_state = LOAD_STALL;
               end
            end
            LOAD_STALL: begin
               if (mem_block) begin
                  en        = 5'b00000;
                  nxt_state = MEM_WAIT;
               end
            end
            BR_FLUSH: begin
               if (mem_block) begin
                  en        = 5'b00000;
                  nxt_state = MEM_WAIT;
               end else begin
                  fl_d = 1'b1;
               end
            end
            MEM_WAIT: begin
               en        = {5{hz.dresp_ready}};
               nxt_state = hz.dresp_ready ? RUN : MEM_WAIT;
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_state <= RUN;
         stall_cnt <= 16'd0;
      end else begin
         cur_state <= nxt_state;
         if (!en[4] && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign hz.fetch_enable     = en[4];
   assign hz.decode_enable    = en[3];
   assign hz.execute_enable   = en[2];
   assign hz.memory_enable    = en[1];
   assign hz.writeback_enable = en[0];
   assign hz.flush_decode     = fl_d;
   assign hz.flush_execute    = fl_e;
   assign hz.fwd_a            = fwd_sel(hz.d_rs, hz.m_dst, hz.m_reg_write, hz.w_dst, hz.w_reg_write);
   assign hz.fwd_b            = fwd_sel(hz.d_rt, hz.m_dst, hz.m_reg_write, hz.w_dst, hz.w_reg_write);
   assign hz.state            = cur_state;
   assign hz.stall_count      = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz ();
   pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));

   typedef struct {
      logic       dv;
      logic [4:0] rs, rt, ed;
      logic       erw, em2r;
      logic [4:0] md;
      logic       mrw;
      logic [4:0] wd;
      logic       wrw, br, dreq, dresp;
      logic [4:0] en;
      logic       fd, fe;
      logic [1:0] fa, fb, nst;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vt[15];

   // Reference model: pending-obligation flags rather than a state register.
   bit   m_wait, m_brtail, m_ldtail;
   int   m_stalls;

   function automatic vec_t mk(int dv, int rs, int rt, int ed, int erw, int em2r,
                               int md, int mrw, int wd, int wrw, int br, int dreq, int dresp,
                               int en, int fd, int fe, int fa, int fb, int nst);
      vec_t v;
      v.dv = dv[0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.ed = ed[4:0];
      v.erw = erw[0]; v.em2r = em2r[0]; v.md = md[4:0]; v.mrw = mrw[0];
      v.wd = wd[4:0]; v.wrw = wrw[0]; v.br = br[0]; v.dreq = dreq[0]; v.dresp = dresp[0];
      v.en = en[4:0]; v.fd = fd[0]; v.fe = fe[0]; v.fa = fa[1:0]; v.fb = fb[1:0]; v.nst = nst[1:0];
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      hz.d_valid = v.dv; hz.d_rs = v.rs; hz.d_rt = v.rt; hz.e_dst = v.ed;
      hz.e_reg_write = v.erw; hz.e_mem_to_reg = v.em2r;
      hz.m_dst = v.md; hz.m_reg_write = v.mrw; hz.w_dst = v.wd; hz.w_reg_write = v.wrw;
      hz.branch_judge = v.br; hz.dreq_valid = v.dreq; hz.dresp_ready = v.dresp;
   endtask

   function automatic int dut_en();
      return {27'd0, hz.fetch_enable, hz.decode_enable, hz.execute_enable,
              hz.memory_enable, hz.writeback_enable};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   function automatic int ref_fwd(logic [4:0] src);
      if (hz.m_reg_write && hz.m_dst != 0 && hz.m_dst == src) return 1;
      if (hz.w_reg_write && hz.w_dst != 0 && hz.w_dst == src) return 2;
      return 0;
   endfunction

   task automatic model_cycle(input int cyc);
      bit lu, mb;
      int en, fd, fe, st;
      lu = hz.d_valid && hz.e_mem_to_reg && hz.e_reg_write && hz.e_dst != 0 &&
           (hz.e_dst == hz.d_rs || hz.e_dst == hz.d_rt);
      mb = hz.dreq_valid && !hz.dresp_ready;
      en = 31; fd = 0; fe = 0;
      st = m_wait ? 3 : m_brtail ? 2 : m_ldtail ? 1 : 0;
      if (!reset)                       begin en = 0; fd = 1; fe = 1; end
      else if (m_wait)                  en = hz.dresp_ready ? 31 : 0;
      else if (mb)                      en = 0;
      else if (m_brtail)                fd = 1;
      else if (m_ldtail)                en = 31;
      else if (hz.branch_judge)         begin fd = 1; fe = 1; end
      else if (lu)                      en = 3;
      chk($sformatf("rand_en@%0d", cyc), dut_en(), en);
      chk($sformatf("rand_flush@%0d", cyc), {hz.flush_decode, hz.flush_execute}, fd * 2 + fe);
      chk($sformatf("rand_fwd@%0d", cyc), {hz.fwd_a, hz.fwd_b}, ref_fwd(hz.d_rs) * 4 + ref_fwd(hz.d_rt));
      chk($sformatf("rand_state@%0d", cyc), hz.state, st);
      chk($sformatf("rand_stall@%0d", cyc), hz.stall_count, m_stalls);
      if (!reset) begin
         m_wait = 0; m_brtail = 0; m_ldtail = 0; m_stalls = 0;
      end else begin
         bit idle;
         idle = !m_wait && !m_brtail && !m_ldtail;
         if ((en & 16) == 0 && m_stalls < 65535) m_stalls++;
         m_brtail = idle && !mb && hz.branch_judge;
         m_ldtail = idle && !mb && !hz.branch_judge && lu;
         m_wait   = m_wait ? !hz.dresp_ready : mb;
      end
   endtask

   initial begin
      vt[0]  = mk(1,1,2,0,0,0, 0,0,0,0, 0,0,0,  31,0,0,0,0,0);
      vt[1]  = mk(1,8,0,8,1,1, 0,0,0,0, 0,0,0,   3,0,0,0,0,1);
      vt[2]  = mk(1,3,9,9,1,1, 0,0,0,0, 0,0,0,   3,0,0,0,0,1);
      vt[3]  = mk(1,0,0,0,1,1, 0,0,0,0, 0,0,0,  31,0,0,0,0,0);
      vt[4]  = mk(0,8,0,8,1,1, 0,0,0,0, 0,0,0,  31,0,0,0,0,0);
      vt[5]  = mk(1,1,2,0,0,0, 0,0,0,0, 1,0,0,  31,1,1,0,0,2);
      vt[6]  = mk(1,1,2,0,0,0, 0,0,0,0, 0,1,0,   0,0,0,0,0,3);
      vt[7]  = mk(1,1,2,0,0,0, 0,0,0,0, 0,1,1,  31,0,0,0,0,0);
      vt[8]  = mk(1,8,0,8,1,1, 0,0,0,0, 1,1,0,   0,0,0,0,0,3);
      vt[9]  = mk(1,8,0,8,1,1, 0,0,0,0, 1,0,0,  31,1,1,0,0,2);
      vt[10] = mk(1,5,0,0,0,0, 5,1,5,1, 0,0,0,  31,0,0,1,0,0);
      vt[11] = mk(1,5,5,0,0,0, 5,0,5,1, 0,0,0,  31,0,0,2,2,0);
      vt[12] = mk(1,0,0,0,0,0, 0,1,0,1, 0,0,0,  31,0,0,0,0,0);
      vt[13] = mk(1,6,7,0,0,0, 7,1,6,1, 0,0,0,  31,0,0,2,1,0);
      vt[14] = mk(1,8,8,8,0,1, 0,0,0,0, 0,0,0,  31,0,0,0,0,0);

      // Reset holds every stage and squashes, whatever the inputs ask for.
      apply(vt[5]);
      hz.dreq_valid = 1'b1;
      reset = 1'b0;
      #1;
      chk("reset_en", dut_en(), 0);
      chk("reset_flush", {hz.flush_decode, hz.flush_execute}, 3);
      tick();
      chk("reset_state", hz.state, 0);
      chk("reset_stall", hz.stall_count, 0);

      for (int i = 0; i < 15; i++) begin
         do_reset();
         apply(vt[i]);
         #1;
         chk($sformatf("vec%0d_en", i), dut_en(), vt[i].en);
         chk($sformatf("vec%0d_flush", i), {hz.flush_decode, hz.flush_execute}, {vt[i].fd, vt[i].fe});
         chk($sformatf("vec%0d_fwd_a", i), hz.fwd_a, vt[i].fa);
         chk($sformatf("vec%0d_fwd_b", i), hz.fwd_b, vt[i].fb);
         tick();
         chk($sformatf("vec%0d_next_state", i), hz.state, vt[i].nst);
      end

      // Load-use: one stall cycle, then execute holds a bubble.
      do_reset();
      apply(vt[1]);
      #1;
      chk("lu_fetch_en", hz.fetch_enable, 0);
      tick();
      hz.e_mem_to_reg = 1'b0;
      #1;
      chk("lu_state", hz.state, 1);
      chk("lu_release_en", dut_en(), 31);
      tick();
      chk("lu_back_run", hz.state, 0);
      chk("lu_stall_count", hz.stall_count, 1);

      // Branch: full flush, then decode-only flush, then RUN.
      do_reset();
      apply(vt[5]);
      #1;
      chk("br_c1_flush", {hz.flush_decode, hz.flush_execute}, 3);
      tick();
      hz.branch_judge = 1'b0;
      #1;
      chk("br_c2_state", hz.state, 2);
      chk("br_c2_flush", {hz.flush_decode, hz.flush_execute}, 2);
      tick();
      chk("br_c3_state", hz.state, 0);

      // Memory wait for three cycles.
      do_reset();
      apply(vt[6]);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("mw_en_c%0d", c), dut_en(), 0);
         tick();
      end
      hz.dresp_ready = 1'b1;
      #1;
      chk("mw_ready_en", dut_en(), 31);
      chk("mw_ready_state", hz.state, 3);
      tick();
      chk("mw_done_state", hz.state, 0);
      chk("mw_stall_count", hz.stall_count, 3);

      // Simultaneous events: memory first, branch serviced after the wait.
      do_reset();
      apply(vt[8]);
      #1;
      chk("sim_en", dut_en(), 0);
      chk("sim_flush", {hz.flush_decode, hz.flush_execute}, 0);
      tick();
      chk("sim_state", hz.state, 3);
      hz.dresp_ready = 1'b1;
      #1;
      chk("sim_ready_flush", {hz.flush_decode, hz.flush_execute}, 0);
      tick();
      hz.dreq_valid = 1'b0;
      #1;
      chk("sim_br_flush", {hz.flush_decode, hz.flush_execute}, 3);
      tick();
      chk("sim_br_state", hz.state, 2);

      // Reset abandons MEM_WAIT.
      do_reset();
      apply(vt[6]);
      tick();
      tick();
      chk("rmw_state", hz.state, 3);
      reset = 1'b0;
      #1;
      chk("rmw_reset_en", dut_en(), 0);
      tick();
      reset = 1'b1;
      hz.dreq_valid = 1'b0;
      #1;
      chk("rmw_state_after", hz.state, 0);
      chk("rmw_stall_after", hz.stall_count, 0);
      chk("rmw_en_after", dut_en(), 31);

      // Randomized run against the reference model.
      do_reset();
      m_wait = 0; m_brtail = 0; m_ldtail = 0; m_stalls = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset           = ($urandom_range(0, 39) != 0);
         hz.d_valid      = $urandom_range(0, 3) != 0;
         hz.d_rs         = 5'($urandom_range(0, 3));
         hz.d_rt         = 5'($urandom_range(0, 3));
         hz.e_dst        = 5'($urandom_range(0, 3));
         hz.e_reg_write  = $urandom_range(0, 1) != 0;
         hz.e_mem_to_reg = $urandom_range(0, 1) != 0;
         hz.m_dst        = 5'($urandom_range(0, 3));
         hz.m_reg_write  = $urandom_range(0, 1) != 0;
         hz.w_dst        = 5'($urandom_range(0, 3));
         hz.w_reg_write  = $urandom_range(0, 1) != 0;
         hz.branch_judge = $urandom_range(0, 4) == 0;
         hz.dreq_valid   = $urandom_range(0, 3) == 0;
         hz.dresp_ready  = $urandom_range(0, 1) != 0;
         #1;
         model_cycle(cyc);
         tick();
      end

      // Saturation of the stall counter.
      do_reset();
      apply(vt[6]);
      repeat (65540) tick();
      chk("sat_stall", hz.stall_count, 65535);
      tick();
      chk("sat_stall_hold", hz.stall_count, 65535);
      chk("sat_state", hz.state, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
